// File: rtl/serial_addsub_if.sv
// Operand/result bundle between the calculator operand registers and the bit-serial adder/subtractor.
// The requester drives start/mode/operands; the unit returns result, flags, busy and the done pulse.
interface serial_addsub_if #(parameter int WIDTH = 9);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry_out;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, opA, opB,
    input  result, overflow, carry_out, busy, done
  );

  modport slave (
    input  start, mode, opA, opB,
    output result, overflow, carry_out, busy, done
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/sub, LSB first through one full adder; result WIDTH cycles after start.
// No backpressure: start is taken only in IDLE, ignored while busy; result/flags hold until the next completion.
module serial_addsub #(
  parameter int WIDTH = 9
) (
  input  logic           relogio,
  input  logic           reset,
  serial_addsub_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr, res_q;
  logic [CW-1:0]    cnt;
  logic             c, ovf_q, cout_q, done_q;
  logic             sum, c_nxt, last, capture;

  always_comb begin
    sum       = sa[0] ^ sb[0] ^ c;
    c_nxt     = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    last      = 1'b0;
    capture   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge relogio or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Subtraction is A + ~B + 1: B is inverted at capture and the carry flop seeded with mode.
  always_ff @(posedge relogio or posedge reset) begin
    if (reset) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      res_q  <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (capture) begin
        sa  <= bus.opA;
        sb  <= bus.mode ? ~bus.opB : bus.opB;
        c   <= bus.mode;
        cnt <= '0;
      end else if (state == RUN) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        sr  <= {sum, sr[WIDTH-1:1]};
        c   <= c_nxt;
        cnt <= cnt + CW'(1);
        // c still holds the carry into the MSB while the last bit is processed.
        if (last) begin
          res_q  <= {sum, sr[WIDTH-1:1]};
          cout_q <= c_nxt;
          ovf_q  <= c_nxt ^ c;
        end
      end
    end
  end

  assign bus.result    = res_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state == RUN);
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: 9-bit and 4-bit instances, directed vectors with hand-computed results.
module tb_serial_addsub;
  logic relogio = 1'b0;
  logic reset   = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;

  always #5 relogio = ~relogio;
  always @(posedge relogio) cyc++;

  serial_addsub_if #(.WIDTH(9)) b9 ();
  serial_addsub_if #(.WIDTH(4)) b4 ();

  serial_addsub #(.WIDTH(9)) dut9 (.relogio(relogio), .reset(reset), .bus(b9.slave));
  serial_addsub #(.WIDTH(4)) dut4 (.relogio(relogio), .reset(reset), .bus(b4.slave));

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        cout;
    int          cyc;
  } exp_t;

  exp_t q9[$];
  exp_t q4[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Monitors: every done pulse pops one expected entry, including the completion cycle.
  always @(negedge relogio) begin
    if (!reset) begin
      chk("busy_done_excl9", {31'b0, b9.busy & b9.done}, 32'd0);
      if (b9.done) begin
        chk("done_expected9", {31'b0, q9.size() != 0}, 32'd1);
        if (q9.size() != 0) begin
          exp_t e;
          e = q9.pop_front();
          chk("result9", {23'b0, b9.result}, e.res);
          chk("overflow9", {31'b0, b9.overflow}, {31'b0, e.ovf});
          chk("carry9", {31'b0, b9.carry_out}, {31'b0, e.cout});
          chk("latency9", cyc, e.cyc);
        end
      end
    end
  end

  always @(negedge relogio) begin
    if (!reset && b4.done) begin
      chk("done_expected4", {31'b0, q4.size() != 0}, 32'd1);
      if (q4.size() != 0) begin
        exp_t e;
        e = q4.pop_front();
        chk("result4", {28'b0, b4.result}, e.res);
        chk("overflow4", {31'b0, b4.overflow}, {31'b0, e.ovf});
        chk("carry4", {31'b0, b4.carry_out}, {31'b0, e.cout});
        chk("latency4", cyc, e.cyc);
      end
    end
  end

  // Called at a falling edge; start is sampled at the next rising edge.
  task automatic issue9(input logic m, input logic [8:0] a, input logic [8:0] b,
                        input logic [8:0] r, input logic v, input logic co);
    exp_t e;
    b9.mode  = m;
    b9.opA   = a;
    b9.opB   = b;
    b9.start = 1'b1;
    e.res  = {23'b0, r};
    e.ovf  = v;
    e.cout = co;
    e.cyc  = cyc + 1 + 9;
    q9.push_back(e);
    @(negedge relogio);
    b9.start = 1'b0;
  endtask

  task automatic wait_done9(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge relogio);
      if (b9.done) seen = 1'b1;
    end
    chk(name, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    b9.start = 1'b0; b9.mode = 1'b0; b9.opA = '0; b9.opB = '0;
    b4.start = 1'b0; b4.mode = 1'b0; b4.opA = '0; b4.opB = '0;
    repeat (2) @(negedge relogio);
    chk("rst_result", {23'b0, b9.result}, 32'd0);
    chk("rst_overflow", {31'b0, b9.overflow}, 32'd0);
    chk("rst_carry", {31'b0, b9.carry_out}, 32'd0);
    chk("rst_busy", {31'b0, b9.busy}, 32'd0);
    chk("rst_done", {31'b0, b9.done}, 32'd0);
    reset = 1'b0;
    @(negedge relogio);

    issue9(1'b1, 9'd5, 9'd3, 9'h002, 1'b0, 1'b1);
    chk("busy_in_run", {31'b0, b9.busy}, 32'd1);
    wait_done9("wait_sub_5_3");
    // Back-to-back: start coincides with the done cycle.
    issue9(1'b1, 9'd3, 9'd5, 9'h1FE, 1'b0, 1'b0);
    wait_done9("wait_sub_3_5");
    issue9(1'b0, 9'h0FF, 9'h001, 9'h100, 1'b1, 1'b0);
    wait_done9("wait_add_ovf");
    issue9(1'b1, 9'h100, 9'h001, 9'h0FF, 1'b1, 1'b1);
    wait_done9("wait_sub_ovf");
    repeat (3) @(negedge relogio);
    chk("result_hold", {23'b0, b9.result}, 32'h0FF);

    // Abort mid-run: result and flags drop to zero immediately, no done follows.
    b9.mode = 1'b0; b9.opA = 9'h123; b9.opB = 9'h045; b9.start = 1'b1;
    @(negedge relogio);
    b9.start = 1'b0;
    repeat (3) @(negedge relogio);
    chk("partial_hidden", {23'b0, b9.result}, 32'h0FF);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, b9.busy}, 32'd0);
    chk("abort_done", {31'b0, b9.done}, 32'd0);
    chk("abort_result", {23'b0, b9.result}, 32'd0);
    chk("abort_overflow", {31'b0, b9.overflow}, 32'd0);
    chk("abort_carry", {31'b0, b9.carry_out}, 32'd0);
    @(negedge relogio);
    reset = 1'b0;
    repeat (12) @(negedge relogio);
    chk("idle_after_abort", {31'b0, b9.busy}, 32'd0);

    issue9(1'b0, 9'h1FF, 9'h001, 9'h000, 1'b0, 1'b1);
    wait_done9("wait_add_wrap");

    // Operand changes and a second start three cycles in must not disturb the op in flight.
    issue9(1'b0, 9'h0A5, 9'h03C, 9'h0E1, 1'b0, 1'b0);
    repeat (2) @(negedge relogio);
    b9.mode = 1'b1; b9.opA = 9'h1FF; b9.opB = 9'h077; b9.start = 1'b1;
    @(negedge relogio);
    b9.start = 1'b0;
    wait_done9("wait_ignore_start");
    repeat (12) @(negedge relogio);

    issue9(1'b1, 9'h000, 9'h100, 9'h100, 1'b1, 1'b0);
    wait_done9("wait_neg_min");

    begin
      exp_t e;
      logic seen = 1'b0;
      b4.mode = 1'b0; b4.opA = 4'd7; b4.opB = 4'd1; b4.start = 1'b1;
      e.res = 32'h8; e.ovf = 1'b1; e.cout = 1'b0; e.cyc = cyc + 1 + 4;
      q4.push_back(e);
      @(negedge relogio);
      b4.start = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge relogio);
        if (b4.done) seen = 1'b1;
      end
      chk("wait_w4", {31'b0, seen}, 32'd1);
    end

    repeat (4) @(negedge relogio);
    chk("queue9_empty", q9.size(), 32'd0);
    chk("queue4_empty", q4.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
